// File: rtl/uart_bus_seq.sv
// uart_bus_seq: dbus master that programs the UART baud divisor, writes TX bytes
// after a busy poll, and polls RX bytes into a one-entry output buffer.
module uart_bus_seq #(
    parameter logic [31:0] TXDATA_ADDR = 32'h0,
    parameter logic [31:0] RXDATA_ADDR = 32'h4,
    parameter logic [31:0] BAUD_ADDR   = 32'h8,
    parameter logic [15:0] BAUD_INIT   = 16'h10,
    parameter int          POLL_GAP    = 4,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    input  logic        rx_en_i,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    input  logic        cfg_baud_wr_i,
    input  logic [15:0] cfg_baud_i,
    output logic        bus_req_o,
    output logic        bus_w_en_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_w_data_o,
    input  logic [31:0] bus_r_data_i,
    input  logic        bus_ack_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [2:0] {INIT, IDLE, BAUD_WR, TX_POLL, TX_WR, RX_POLL, GAP} state_t;
    state_t      state;
    logic        holding_full, tx_ok, init_done, baud_pend, rr;
    logic [7:0]  tx_byte, cnt;
    logic [15:0] baud_val;
    logic        timed_out, tx_elig, rx_elig, unused_rdata;

    assign tx_elig      = holding_full;
    assign rx_elig      = rx_en_i & ~rx_valid_o;
    assign tx_ready_o   = ~holding_full & init_done;
    assign busy_o       = ~rst & ((state != IDLE) | holding_full | baud_pend | rx_elig);
    assign timed_out    = bus_req_o & ~bus_ack_i & (cnt == 8'(ACK_TIMEOUT - 1));
    assign unused_rdata = ^bus_r_data_i[30:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            bus_req_o    <= 1'b0;
            bus_w_en_o   <= 1'b0;
            bus_addr_o   <= '0;
            bus_w_data_o <= '0;
            holding_full <= 1'b0;
            tx_byte      <= '0;
            tx_ok        <= 1'b0;
            init_done    <= 1'b0;
            baud_pend    <= 1'b0;
            baud_val     <= '0;
            rr           <= 1'b0;
            rx_valid_o   <= 1'b0;
            rx_data_o    <= '0;
            err_o        <= 1'b0;
            cnt          <= '0;
        end else begin
            cnt <= cnt + 8'd1;
            if (tx_valid_i & tx_ready_o) begin
                holding_full <= 1'b1;
                tx_byte      <= tx_data_i;
            end
            if (rx_valid_o & rx_ready_i) rx_valid_o <= 1'b0;
            // cnt times the outstanding request, and the idle gap when req is low
            if (timed_out) begin
                bus_req_o <= 1'b0;
                err_o     <= 1'b1;
                state     <= IDLE;
                if (state == TX_WR) begin
                    holding_full <= 1'b0;
                    tx_ok        <= 1'b0;
                end
            end else begin
                case (state)
                    INIT: begin
                        if (!bus_req_o) begin
                            bus_req_o    <= 1'b1;
                            bus_w_en_o   <= 1'b1;
                            bus_addr_o   <= BAUD_ADDR;
                            bus_w_data_o <= {16'h0, BAUD_INIT};
                            cnt          <= '0;
                        end else if (bus_ack_i) begin
                            bus_req_o <= 1'b0;
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    IDLE: begin
                        cnt <= '0;
                        if (!init_done) state <= INIT;
                        else if (baud_pend) begin
                            state        <= BAUD_WR;
                            bus_req_o    <= 1'b1;
                            bus_w_en_o   <= 1'b1;
                            bus_addr_o   <= BAUD_ADDR;
                            bus_w_data_o <= {16'h0, baud_val};
                        end else if (tx_elig & (~rx_elig | ~rr)) begin
                            state        <= tx_ok ? TX_WR : TX_POLL;
                            bus_req_o    <= 1'b1;
                            bus_w_en_o   <= tx_ok;
                            bus_addr_o   <= TXDATA_ADDR;
                            bus_w_data_o <= tx_ok ? {24'h0, tx_byte} : '0;
                            rr           <= 1'b1;
                        end else if (rx_elig) begin
                            state        <= RX_POLL;
                            bus_req_o    <= 1'b1;
                            bus_w_en_o   <= 1'b0;
                            bus_addr_o   <= RXDATA_ADDR;
                            bus_w_data_o <= '0;
                            rr           <= 1'b0;
                        end
                    end
                    BAUD_WR: if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        baud_pend <= 1'b0;
                        state     <= IDLE;
                    end
                    TX_POLL: if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        tx_ok     <= ~bus_r_data_i[31];
                        cnt       <= '0;
                        state     <= bus_r_data_i[31] ? GAP : IDLE;
                    end
                    TX_WR: if (bus_ack_i) begin
                        bus_req_o    <= 1'b0;
                        holding_full <= 1'b0;
                        tx_ok        <= 1'b0;
                        state        <= IDLE;
                    end
                    RX_POLL: if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        cnt       <= '0;
                        state     <= bus_r_data_i[31] ? GAP : IDLE;
                        if (!bus_r_data_i[31]) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= bus_r_data_i[7:0];
                        end
                    end
                    GAP: if (cnt == 8'(POLL_GAP - 1)) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            // a fresh request wins over a BAUD_WR ack on the same edge
            if (cfg_baud_wr_i) begin
                baud_pend <= 1'b1;
                baud_val  <= cfg_baud_i;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_seq.sv
// tb_uart_bus_seq: directed bench with a UART slave model, a transaction log and
// a bus-level behavioural model checked every cycle.
module tb_uart_bus_seq;
    localparam int POLL_GAP = 4;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 0, rst = 1;
    logic        tx_valid_i = 0, rx_en_i = 0, rx_ready_i = 0, cfg_baud_wr_i = 0;
    logic [7:0]  tx_data_i = 0;
    logic [15:0] cfg_baud_i = 0;
    logic        tx_ready_o, rx_valid_o, bus_req_o, bus_w_en_o, busy_o, err_o;
    logic [7:0]  rx_data_o;
    logic [31:0] bus_addr_o, bus_w_data_o;
    logic [31:0] bus_r_data_i = 0;
    logic        bus_ack_i = 0;

    uart_bus_seq dut (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
        .rx_en_i(rx_en_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
        .cfg_baud_wr_i(cfg_baud_wr_i), .cfg_baud_i(cfg_baud_i), .bus_req_o(bus_req_o),
        .bus_w_en_o(bus_w_en_o), .bus_addr_o(bus_addr_o), .bus_w_data_o(bus_w_data_o),
        .bus_r_data_i(bus_r_data_i), .bus_ack_i(bus_ack_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    typedef struct {logic [31:0] a; logic w; logic [31:0] d; int s; int e; logic to;} txn_t;
    txn_t log_q[$];
    function automatic logic [63:0] tx(logic w, logic [7:0] a, logic [31:0] d);
        return {23'b0, w, a, d};
    endfunction
    function automatic logic [63:0] txn(int i);
        if (i >= log_q.size()) return '1;
        return tx(log_q[i].w, log_q[i].a[7:0], log_q[i].d);
    endfunction

    // UART slave: registered one-cycle ack, scripted read responses
    logic [31:0] tx_q[$], rx_q[$];
    logic [31:0] tx_default = 0, rx_default = 32'h8000_0000;
    logic        mute_wr = 0;
    always @(posedge clk) begin
        if (bus_req_o && !bus_ack_i && !(mute_wr && bus_w_en_o && bus_addr_o == 0)) begin
            bus_ack_i <= 1;
            if (bus_w_en_o) bus_r_data_i <= 0;
            else if (bus_addr_o == 0) begin
                if (tx_q.size() > 0) bus_r_data_i <= tx_q.pop_front();
                else bus_r_data_i <= tx_default;
            end else begin
                if (rx_q.size() > 0) bus_r_data_i <= rx_q.pop_front();
                else bus_r_data_i <= rx_default;
            end
        end else bus_ack_i <= 0;
    end

    // Behavioural model: derives expected outputs from observed bus transactions
    int   cyc = 0, req_len = 0, start_edge = 0, last_accept = 0;
    logic in_rst = 1, must_drop = 0, m_init = 0, m_hold = 0, m_rxv = 0, m_err = 0;
    logic [7:0] m_rxd = 0;
    always @(posedge clk) begin
        logic hs;
        cyc++;
        in_rst = rst;
        must_drop = 0;
        if (rst) begin
            m_init = 0; m_hold = 0; m_rxv = 0; m_err = 0; req_len = 0; must_drop = 1;
        end else begin
            hs = m_rxv & rx_ready_i;
            if (tx_valid_i && m_init && !m_hold) begin
                m_hold = 1;
                last_accept = cyc;
            end
            req_len = bus_req_o ? req_len + 1 : 0;
            if (req_len == 1) start_edge = cyc;
            if (bus_req_o && bus_ack_i) begin
                log_q.push_back('{bus_addr_o, bus_w_en_o, bus_w_data_o, start_edge, cyc, 1'b0});
                must_drop = 1;
                if (bus_w_en_o && bus_addr_o == 8) m_init = 1;
                if (bus_w_en_o && bus_addr_o == 0) m_hold = 0;
                if (!bus_w_en_o && bus_addr_o == 4 && !bus_r_data_i[31]) begin
                    m_rxv = 1;
                    m_rxd = bus_r_data_i[7:0];
                end
            end else if (bus_req_o && req_len == ACK_TIMEOUT) begin
                log_q.push_back('{bus_addr_o, bus_w_en_o, bus_w_data_o, start_edge, cyc, 1'b1});
                must_drop = 1;
                m_err = 1;
                if (bus_w_en_o && bus_addr_o == 0) m_hold = 0;
            end
            if (hs) m_rxv = 0;
        end
    end

    logic        p_req = 0;
    logic [63:0] p_fields = 0;
    always @(negedge clk) begin
        if (!in_rst) begin
            chk("tx_ready", tx_ready_o, m_init & ~m_hold);
            chk("rx_valid", rx_valid_o, m_rxv);
            if (m_rxv) chk("rx_data", rx_data_o, m_rxd);
            chk("err", err_o, m_err);
            if (must_drop) chk("req_drop", bus_req_o, 0);
            if (bus_req_o && p_req) chk("req_hold", tx(bus_w_en_o, bus_addr_o[7:0], bus_w_data_o), p_fields);
        end
        p_req = bus_req_o & ~in_rst;
        p_fields = tx(bus_w_en_o, bus_addr_o[7:0], bus_w_data_o);
    end

    task automatic send(input logic [7:0] b);
        for (int i = 0; i < 300 && !tx_ready_o; i++) @(negedge clk);
        chk("send_ready", tx_ready_o, 1);
        tx_valid_i = 1;
        tx_data_i = b;
        @(negedge clk);
        tx_valid_i = 0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400 && log_q.size() < n; i++) @(negedge clk);
        chk("wait_log", log_q.size() >= n, 1);
    endtask

    initial begin
        int mark, n;
        // reset state and INIT baud write
        repeat (3) @(negedge clk);
        chk("rst_req", bus_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_addr", {bus_addr_o, bus_w_data_o}, 0);
        chk("rst_rx", {rx_valid_o, rx_data_o, err_o}, 0);
        rst = 0;
        @(negedge clk);
        chk("init_busy", busy_o, 1);
        chk("init_req", {bus_req_o, tx(bus_w_en_o, bus_addr_o[7:0], bus_w_data_o)}, {1'b1, tx(1, 8'h08, 32'h10)});
        @(negedge clk);
        chk("init_ready_low", tx_ready_o, 0);
        @(negedge clk);
        chk("init_ready_high", tx_ready_o, 1);
        chk("init_log", txn(0), tx(1, 8'h08, 32'h10));

        // uncontended byte: poll, write, ready six edges after accept
        mark = log_q.size();
        send(8'h3C);
        wait_log(mark + 2);
        chk("lat_poll", txn(mark), tx(0, 8'h00, 0));
        chk("lat_write", txn(mark + 1), tx(1, 8'h00, 32'h3C));
        chk("lat_edges", log_q[mark + 1].e - last_accept, 6);

        // busy twice then ready: gap state plus idle cycle between busy polls
        tx_q.push_back(32'h8000_0000);
        tx_q.push_back(32'h8000_0000);
        repeat (3) @(negedge clk);
        mark = log_q.size();
        send(8'h4A);
        wait_log(mark + 4);
        chk("busy_poll0", txn(mark), tx(0, 8'h00, 0));
        chk("busy_poll1", txn(mark + 1), tx(0, 8'h00, 0));
        chk("busy_poll2", txn(mark + 2), tx(0, 8'h00, 0));
        chk("busy_write", txn(mark + 3), tx(1, 8'h00, 32'h4A));
        chk("gap1", log_q[mark + 1].s - log_q[mark].e, POLL_GAP + 2);
        chk("gap2", log_q[mark + 2].s - log_q[mark + 1].e, POLL_GAP + 2);
        chk("nogap", log_q[mark + 3].s - log_q[mark + 2].e, 2);
        @(negedge clk);
        chk("busy_ready", tx_ready_o, 1);

        // RX: empty then 0x55, held without further reads until handshake
        rx_q.push_back(32'h8000_0000);
        rx_q.push_back(32'h0000_0055);
        mark = log_q.size();
        rx_en_i = 1;
        for (int i = 0; i < 100 && !rx_valid_o; i++) @(negedge clk);
        chk("rx_got", {rx_valid_o, rx_data_o}, {1'b1, 8'h55});
        chk("rx_lat", cyc, (log_q.size() > mark + 1) ? log_q[mark + 1].e : -1);
        chk("rx_gap", log_q[mark + 1].s - log_q[mark].e, POLL_GAP + 2);
        repeat (20) @(negedge clk);
        n = 0;
        for (int i = mark; i < log_q.size(); i++) if (log_q[i].a == 4) n++;
        chk("rx_reads", n, 2);
        rx_ready_i = 1;
        rx_en_i = 0;
        @(negedge clk);
        rx_ready_i = 0;
        chk("rx_cleared", rx_valid_o, 0);

        // arbitration after reset: baud first, then TX/RX alternate
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 50 && !tx_ready_o; i++) @(negedge clk);
        tx_default = 32'h8000_0000;
        mark = log_q.size();
        tx_valid_i = 1; tx_data_i = 8'h11;
        cfg_baud_wr_i = 1; cfg_baud_i = 16'h000A;
        @(negedge clk);
        tx_valid_i = 0; cfg_baud_wr_i = 0; rx_en_i = 1;
        wait_log(mark + 6);
        chk("arb0", txn(mark), tx(1, 8'h08, 32'h0A));
        chk("arb1", txn(mark + 1), tx(0, 8'h00, 0));
        chk("arb2", txn(mark + 2), tx(0, 8'h04, 0));
        chk("arb3", txn(mark + 3), tx(0, 8'h00, 0));
        chk("arb4", txn(mark + 4), tx(0, 8'h04, 0));
        chk("arb5", txn(mark + 5), tx(0, 8'h00, 0));
        rx_en_i = 0;
        tx_default = 0;
        for (int i = 0; i < 100 && !tx_ready_o; i++) @(negedge clk);
        chk("arb_sent", txn(log_q.size() - 1), tx(1, 8'h00, 32'h11));

        // TX write never acked: timeout, sticky error, byte discarded
        mute_wr = 1;
        mark = log_q.size();
        send(8'h77);
        for (int i = 0; i < 100 && !err_o; i++) @(negedge clk);
        chk("to_err", err_o, 1);
        chk("to_ready", tx_ready_o, 1);
        chk("to_entry", {log_q[mark + 1].to, txn(mark + 1)}, {1'b1, tx(1, 8'h00, 32'h77)});
        chk("to_len", log_q[mark + 1].e - log_q[mark + 1].s + 1, ACK_TIMEOUT);
        mute_wr = 0;
        send(8'h78);
        for (int i = 0; i < 100 && !(tx_ready_o && log_q[log_q.size() - 1].d == 32'h78); i++) @(negedge clk);
        chk("to_sticky", err_o, 1);
        chk("to_next", txn(log_q.size() - 1), tx(1, 8'h00, 32'h78));

        // reset while a request is outstanding
        rx_en_i = 1;
        for (int i = 0; i < 50 && !bus_req_o; i++) @(negedge clk);
        chk("mid_req", bus_req_o, 1);
        mark = log_q.size();
        rst = 1;
        @(negedge clk);
        chk("mid_drop", bus_req_o, 0);
        rx_en_i = 0;
        rst = 0;
        wait_log(mark + 1);
        chk("mid_init", txn(mark), tx(1, 8'h08, 32'h10));
        chk("mid_err", err_o, 0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_bus_seq.md
# uart_bus_seq

Hardware bus master that sequences the memory-mapped UART over its dbus slave port, so non-CPU logic (GEMM accelerator result dump, boot loader) can send and receive bytes without software. It programs the baud divisor after reset and on request, polls TXDATA busy before every byte write, and polls and pops RXDATA into a one-entry output buffer. It arbitrates these three operations onto a single UART bus port and times out unacknowledged transactions.

## Interface
- TXDATA_ADDR, 32'h0, byte address of TXDATA register (read: bit31 = busy; write: [7:0] = byte)
- RXDATA_ADDR, 32'h4, byte address of RXDATA register (read: bit31 = empty, [7:0] = data; read pops RX FIFO)
- BAUD_ADDR, 32'h8, byte address of baud divisor register ([15:0])
- BAUD_INIT, 16'h10, divisor written after reset
- POLL_GAP, 4, idle cycles after a not-ready poll (1..255)
- ACK_TIMEOUT, 16, max cycles req may wait for ack (2..255)

- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- tx_valid_i  in  1  byte offered
- tx_data_i  in  8  byte to transmit
- tx_ready_o  out  1  holding register empty; transfer on tx_valid_i & tx_ready_o
- rx_en_i  in  1  level; enables RXDATA polling
- rx_valid_o  out  1  received byte held
- rx_data_o  out  8  received byte
- rx_ready_i  in  1  consumer takes byte on rx_valid_o & rx_ready_i
- cfg_baud_wr_i  in  1  pulse: request baud reprogram
- cfg_baud_i  in  16  new divisor, sampled with cfg_baud_wr_i
- bus_req_o  out  1  dbus request to UART
- bus_w_en_o  out  1  1 = write, 0 = read
- bus_addr_o  out  32  register byte address
- bus_w_data_o  out  32  write data, zero-extended
- bus_r_data_i  in  32  read data, valid with bus_ack_i
- bus_ack_i  in  1  one-cycle registered ack from UART
- busy_o  out  1  FSM not in IDLE or any work pending
- err_o  out  1  sticky: an ack timeout occurred

## Operation
- States: INIT, IDLE, BAUD_WR, TX_POLL, TX_WR, RX_POLL, GAP.
- All bus outputs registered. A transaction: req held with fixed addr/w_en/w_data until bus_ack_i sampled high; req drops the cycle after the ack. Req is low at least one cycle between transactions (FSM passes through IDLE or GAP).
- INIT: write BAUD_INIT to BAUD_ADDR; on ack -> IDLE; tx_ready_o held 0 until then.
- IDLE priority: baud pending > TX/RX round-robin. TX eligible: holding full. RX eligible: rx_en_i & ~rx_valid_o. Round-robin pointer reset favours TX; after a grant, the other side wins next tie.
- Baud pending: set by cfg_baud_wr_i, value latched; a second pulse before service overwrites the value. BAUD_WR clears pending on ack.
- TX_POLL: read TXDATA_ADDR. r_data[31]=1 -> GAP then IDLE (byte stays pending). 0 -> TX_WR: write {24'b0,byte} to TXDATA_ADDR; on ack holding empties.
- RX_POLL: read RXDATA_ADDR. r_data[31]=0 -> rx_data_o <= r_data[7:0], rx_valid_o <= 1, -> IDLE. 1 (empty) -> GAP. No RX read is issued while rx_valid_o=1 (read pops data).
- GAP: req low for POLL_GAP cycles, then IDLE.
- Timeout: cycle counter from req rise; at ACK_TIMEOUT cycles without ack, drop req, set err_o, -> IDLE. Abandoned TX_WR discards byte; abandoned BAUD_WR/INIT leaves pending set and retries; abandoned polls retry normally. Ack arriving after drop is ignored.
- rx_valid_o clears on rx_ready_i handshake; new poll earliest next IDLE.

## Timing
- Reset values: bus_req_o, bus_w_en_o, tx_ready_o, rx_valid_o, err_o = 0; bus_addr_o, bus_w_data_o, rx_data_o = 0; busy_o = 0 during rst, 1 in INIT. rst mid-transaction drops req next edge and abandons it; INIT reruns.
- Accept at edge E: IDLE at E+1, TX_POLL req E+2, ack E+3, IDLE E+4, TX_WR req E+5, ack E+6, tx_ready_o=1 at E+7 (UART idle, no contention).
- tx_ready_o = ~holding_full & init_done; byte accepted in the same cycle tx_ready_o drops.
- RX: poll req to rx_valid_o = 2 cycles with immediate ack.

## Test plan
- Reset release: first transaction is write addr 0x8 data 0x10; tx_ready_o stays 0 until its ack, then 1.
- Send 0x4A with TXDATA read returning bit31=1 twice then 0 -> three reads spaced by 4-cycle gaps, then one write 0x0000004A; tx_ready_o back high 1 cycle after write ack.
- rx_en_i=1, RXDATA returns 0x80000000 then 0x00000055 -> rx_data_o=0x55, rx_valid_o held with rx_ready_i=0 and no further RXDATA reads until handshake.
- TX pending, RX enabled, cfg_baud_wr_i with 0x0A -> order: baud write 0x0A, TX poll, RX poll, alternating thereafter.
- Slave never acks TX_WR -> req drops after 16 cycles, err_o=1 sticky, byte discarded, tx_ready_o=1.
- rst pulsed while req high -> req 0 next cycle, INIT baud write reissued.
